// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - mode encodings and stage control register type for pipe_shifter
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_SRL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  // Control half of every stage register; data, tag and shift bits sit beside it
  typedef struct packed {
    logic  valid;
    mode_e mode;
  } stage_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered barrel stage shifting by 2^SEL; rotate gated by PIPE_SHIFTER_ROR_EN
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int SHW   = 4,
  parameter int SEL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [SHW-1:0]   shval_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [1:0]       mode_o,
  output logic [SHW-1:0]   shval_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int DIST = 1 << SEL;

  stage_ctrl_t      ctrl_d, ctrl_q;
  logic [SHW-1:0]   shval_d, shval_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_i;
    if (shval_i[SEL]) begin
      case (mode_e'(mode_i))
        MODE_SLL: shifted = data_i << DIST;
        MODE_SRA: shifted = $signed(data_i) >>> DIST;
        MODE_SRL: shifted = data_i >> DIST;
`ifdef PIPE_SHIFTER_ROR_EN
        MODE_ROR: shifted = (data_i >> DIST) | (data_i << (WIDTH - DIST));
`endif
        default:  shifted = data_i;
      endcase
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    shval_d = shval_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (adv) begin
      ctrl_d.valid = valid_i;
      ctrl_d.mode  = mode_e'(mode_i);
      shval_d      = shval_i;
      tag_d        = tag_i;
      data_d       = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      shval_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      shval_q <= shval_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = ctrl_q.valid;
  assign mode_o  = ctrl_q.mode;
  assign shval_o = shval_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - log2(WIDTH)-stage pipelined shifter with valid/ready; rotate gated by PIPE_SHIFTER_ROR_EN
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [SHW-1:0]   Shift_Val,
  input  logic [1:0]       Mode,
  input  logic [TAG_W-1:0] Tag_In,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Shift_Out,
  output logic [TAG_W-1:0] Tag_Out,
  output logic             Zero
);

  // Index k is the input of stage k; index SHW is the last stage register
  logic             valid_s [SHW+1];
  logic [1:0]       mode_s  [SHW+1];
  logic [SHW-1:0]   shval_s [SHW+1];
  logic [TAG_W-1:0] tag_s   [SHW+1];
  logic [WIDTH-1:0] data_s  [SHW+1];
  logic             advance;

  assign valid_s[0] = In_Valid;
  assign mode_s[0]  = Mode;
  assign shval_s[0] = Shift_Val;
  assign tag_s[0]   = Tag_In;
  assign data_s[0]  = Shift_In;

  // The whole pipe moves as one, so a stalled output freezes every stage
  assign advance  = !Out_Valid || Out_Ready;
  assign In_Ready = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SHW   (SHW),
      .SEL   (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (advance),
      .valid_i (valid_s[k]),
      .mode_i  (mode_s[k]),
      .shval_i (shval_s[k]),
      .tag_i   (tag_s[k]),
      .data_i  (data_s[k]),
      .valid_o (valid_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .shval_o (shval_s[k+1]),
      .tag_o   (tag_s[k+1]),
      .data_o  (data_s[k+1])
    );
  end

  assign Out_Valid = valid_s[SHW];
  assign Shift_Out = data_s[SHW];
  assign Tag_Out   = tag_s[SHW];
  assign Zero      = Out_Valid && (data_s[SHW] == '0);

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter; honours PIPE_SHIFTER_ROR_EN
module tb_pipe_shifter;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int SHW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Shift_In;
  logic [SHW-1:0]   Shift_Val;
  logic [1:0]       Mode;
  logic [TAG_W-1:0] Tag_In;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Shift_Out;
  logic [TAG_W-1:0] Tag_Out;
  logic             Zero;

  pipe_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .Tag_In    (Tag_In),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Shift_Out (Shift_Out),
    .Tag_Out   (Tag_Out),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int sh,
                                                 input logic [1:0] m);
    logic [2*WIDTH-1:0] w;
    logic [WIDTH-1:0]   r;
    case (m)
      2'b00: r = d << sh;
      2'b01: begin w = {{WIDTH{d[WIDTH-1]}}, d}; w = w >> sh; r = w[WIDTH-1:0]; end
      2'b10: r = d >> sh;
      default: begin
`ifdef PIPE_SHIFTER_ROR_EN
        w = {d, d}; w = w >> sh; r = w[WIDTH-1:0];
`else
        r = d;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboard consumer: a transfer happens at the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
      out_cnt++;
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output got %h tag %h, expected no output", Shift_Out, Tag_Out);
      end else begin
        e = sb.pop_front();
        if (Shift_Out !== e.data || Tag_Out !== e.tag || Zero !== (e.data == '0))
          $display("FAIL result got data %h tag %h zero %b, expected data %h tag %h zero %b",
                   Shift_Out, Tag_Out, Zero, e.data, e.tag, (e.data == '0));
        else
          pass_cnt++;
        if (lat_chk) begin
          chk_cnt++;
          if (cyc - e.acc != SHW)
            $display("FAIL latency got %0d, expected %0d", cyc - e.acc, SHW);
          else
            pass_cnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1);
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                      input logic [1:0] m, input logic [TAG_W-1:0] t, input bit rnd);
    exp_t e;
    bit   done = 0;
    In_Valid = 1'b1; Shift_In = d; Shift_Val = sh; Mode = m; Tag_In = t;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (rnd) Out_Ready = ($urandom_range(0, 3) != 0);
      #1;
      if (In_Ready) begin
        e.data = ref_shift(d, int'(sh), m); e.tag = t; e.acc = cyc;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    In_Valid = 1'b0;
    if (!done) begin
      chk_cnt++;
      $display("FAIL send_timeout got no acceptance, expected In_Ready");
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      if (rnd) Out_Ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 2000 && sb.size() > 0; i++) idle(1, rnd);
    Out_Ready = 1'b1;
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL drain got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic wait_out(input string name, input int want_n);
    int n = 0;
    do begin @(negedge clk); n++; end while (Out_Valid !== 1'b1 && n < 20);
    chk_cnt++;
    if (n != want_n) $display("FAIL %s_latency got %0d, expected %0d", name, n, want_n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
    Shift_In = '0; Shift_Val = '0; Mode = 2'b00; Tag_In = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (Out_Valid !== 1'b0 || Zero !== 1'b0 || In_Ready !== 1'b1)
      $display("FAIL reset_ctrl got v%b z%b r%b, expected v0 z0 r1", Out_Valid, Zero, In_Ready);
    else pass_cnt++;
    chk_cnt++;
    if (Shift_Out !== '0 || Tag_Out !== '0)
      $display("FAIL reset_data got %h/%h, expected 0000/0", Shift_Out, Tag_Out);
    else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0)
      $display("FAIL post_reset got r%b v%b, expected r1 v0", In_Ready, Out_Valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_sll();
    lat_chk = 1;
    send(16'h0001, 4'd15, 2'b00, 4'h3, 0);
    wait_out("sll", 4);
    chk_cnt++;
    if (Shift_Out !== 16'h8000 || Tag_Out !== 4'h3 || Zero !== 1'b0)
      $display("FAIL sll got %h/%h/%b, expected 8000/3/0", Shift_Out, Tag_Out, Zero);
    else pass_cnt++;
    @(posedge clk); #1;
    drain(0);
    lat_chk = 0;
  endtask

  task automatic test_back_to_back();
    int base = out_cnt;
    lat_chk = 1;
    send(16'h8000, 4'd15, 2'b01, 4'h1, 0);
    send(16'h8000, 4'd15, 2'b10, 4'h2, 0);
    send(16'h00F0, 4'd12, 2'b00, 4'h4, 0);
    drain(0);
    lat_chk = 0;
    chk_cnt++;
    if (out_cnt - base != 3) $display("FAIL b2b_count got %0d, expected 3", out_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_zero_shift();
    int base = out_cnt;
    for (int m = 0; m < 4; m++) send(16'hA5C3, 4'd0, 2'(m), 4'(m), 0);
    drain(0);
    chk_cnt++;
    if (out_cnt - base != 4) $display("FAIL zero_shift_count got %0d, expected 4", out_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_ror();
    logic [WIDTH-1:0] want;
`ifdef PIPE_SHIFTER_ROR_EN
    want = 16'h8000;
`else
    want = 16'h0001;
`endif
    send(16'h0001, 4'd1, 2'b11, 4'h5, 0);
    wait_out("ror", 4);
    chk_cnt++;
    if (Shift_Out !== want || Tag_Out !== 4'h5)
      $display("FAIL ror got %h/%h, expected %h/5", Shift_Out, Tag_Out, want);
    else pass_cnt++;
    @(posedge clk); #1;
    drain(0);
  endtask

  task automatic test_stall();
    int base;
    Out_Ready = 1'b0;
    send(16'h1234, 4'd4, 2'b00, 4'h1, 0);
    send(16'h8421, 4'd3, 2'b01, 4'h2, 0);
    send(16'hF00F, 4'd8, 2'b10, 4'h3, 0);
    send(16'h0FF0, 4'd5, 2'b11, 4'h4, 0);
    base = out_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (In_Ready !== 1'b0 || Out_Valid !== 1'b1 || Shift_Out !== sb[0].data || Tag_Out !== sb[0].tag)
        $display("FAIL stall_hold got r%b v%b %h/%h, expected r0 v1 %h/%h",
                 In_Ready, Out_Valid, Shift_Out, Tag_Out, sb[0].data, sb[0].tag);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    Out_Ready = 1'b1;
    drain(0);
    chk_cnt++;
    if (out_cnt - base != 4) $display("FAIL stall_count got %0d, expected 4", out_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    int base;
    bit seen = 0;
    Out_Ready = 1'b1;
    send(16'h00FF, 4'd1, 2'b00, 4'h6, 0);
    send(16'h0F0F, 4'd2, 2'b10, 4'h7, 0);
    send(16'hFFFF, 4'd3, 2'b01, 4'h8, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    base = out_cnt;
    @(negedge clk);
    chk_cnt++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Zero !== 1'b0)
      $display("FAIL flush got v%b r%b z%b, expected v0 r1 z0", Out_Valid, In_Ready, Zero);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Out_Valid !== 1'b0) seen = 1;
    end
    chk_cnt++;
    if (seen || out_cnt != base) $display("FAIL flush_no_output got %0d outputs, expected 0", out_cnt - base);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int base = out_cnt;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1, 1);
      send(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom), 1);
    end
    drain(1);
    chk_cnt++;
    if (out_cnt - base != 10000) $display("FAIL random_count got %0d, expected 10000", out_cnt - base);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sll();
    test_back_to_back();
    test_zero_shift();
    test_ror();
    test_stall();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
